// File: rtl/ara_pkg.sv
// Shared Ara types: element width and the ring transfer command consumed by
// the per-cluster ring transfer sequencer.
package ara_pkg;

  localparam int unsigned ELEN         = 64;
  localparam int unsigned RingCntWidth = 16;

  typedef logic [ELEN-1:0] elen_t;

  // dir: 0 = left / slidedown, 1 = right
  typedef struct packed {
    logic                    dir;
    logic                    bypass;
    logic [RingCntWidth-1:0] len;
  } ring_cmd_t;

endpackage

// File: rtl/ring_xfer_ctrl.sv
// Sequencer between the SLDU and its ring_router: one configuration pulse per
// command, then exactly len words out to the ring and len words back in.
module ring_xfer_ctrl
  import ara_pkg::*;
#(
  parameter int unsigned DataWidth = $bits(elen_t),
  parameter int unsigned CntWidth  = RingCntWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  ring_cmd_t            cmd_i,
  input  logic [DataWidth-1:0] src_data_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  output logic [DataWidth-1:0] dst_data_o,
  output logic                 dst_valid_o,
  input  logic                 dst_ready_i,
  output logic                 ring_dir_o,
  output logic                 ring_bypass_o,
  output logic                 ring_conf_valid_o,
  output logic [DataWidth-1:0] ring_tx_data_o,
  output logic                 ring_tx_valid_o,
  input  logic                 ring_tx_ready_i,
  input  logic [DataWidth-1:0] ring_rx_data_i,
  input  logic                 ring_rx_valid_i,
  output logic                 ring_rx_ready_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONF = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] tx_cnt_q, tx_cnt_d;
  logic [CntWidth-1:0] rx_cnt_q, rx_cnt_d;
  logic [CntWidth-1:0] len_q;
  logic                dir_q, bypass_q;
  logic                in_xfer, tx_open, rx_open;
  logic                tx_fire, rx_fire, cmd_fire;

  // Each path closes on its own once its counter reaches len_q, so the
  // counters saturate and the router never sees an extra beat.
  assign in_xfer  = (state_q == XFER);
  assign tx_open  = in_xfer && (tx_cnt_q < len_q);
  assign rx_open  = in_xfer && (rx_cnt_q < len_q);
  assign cmd_fire = cmd_valid_i && cmd_ready_o;

  assign cmd_ready_o       = (state_q == IDLE);
  assign ring_conf_valid_o = (state_q == CONF);
  assign done_o            = (state_q == DONE);
  assign busy_o            = (state_q != IDLE);
  assign ring_dir_o        = dir_q;
  assign ring_bypass_o     = bypass_q;

  assign ring_tx_data_o  = src_data_i;
  assign ring_tx_valid_o = src_valid_i && tx_open;
  assign src_ready_o     = ring_tx_ready_i && tx_open;
  assign tx_fire         = src_valid_i && ring_tx_ready_i && tx_open;

  assign dst_data_o      = ring_rx_data_i;
  assign dst_valid_o     = ring_rx_valid_i && rx_open;
  assign ring_rx_ready_o = dst_ready_i && rx_open;
  assign rx_fire         = ring_rx_valid_i && dst_ready_i && rx_open;

  assign tx_cnt_d = tx_cnt_q + {{(CntWidth-1){1'b0}}, tx_fire};
  assign rx_cnt_d = rx_cnt_q + {{(CntWidth-1){1'b0}}, rx_fire};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_fire) state_d = CONF;
      CONF: state_d = (bypass_q || (len_q == '0)) ? DONE : XFER;
      XFER: if ((tx_cnt_d == len_q) && (rx_cnt_d == len_q)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      len_q    <= '0;
      dir_q    <= 1'b0;
      bypass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_fire) begin
        dir_q    <= cmd_i.dir;
        bypass_q <= cmd_i.bypass;
        len_q    <= CntWidth'(cmd_i.len);
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
      end else begin
        tx_cnt_q <= tx_cnt_d;
        rx_cnt_q <= rx_cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_ring_xfer_ctrl.sv
// Randomized bench for ring_xfer_ctrl: models SLDU source/sink and the router
// (loopback or free-running rx stream) and checks beats, timing and data.
module tb_ring_xfer_ctrl;
  import ara_pkg::*;

  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  ring_cmd_t     cmd_i = '0;
  logic [DW-1:0] src_data_i = '0;
  logic          src_valid_i = 1'b0;
  logic          src_ready_o;
  logic [DW-1:0] dst_data_o;
  logic          dst_valid_o;
  logic          dst_ready_i = 1'b0;
  logic          ring_dir_o, ring_bypass_o, ring_conf_valid_o;
  logic [DW-1:0] ring_tx_data_o;
  logic          ring_tx_valid_o;
  logic          ring_tx_ready_i = 1'b0;
  logic [DW-1:0] ring_rx_data_i = '0;
  logic          ring_rx_valid_i = 1'b0;
  logic          ring_rx_ready_o;
  logic          busy_o, done_o;

  int total = 0;
  int bad   = 0;

  ring_xfer_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i),
    .src_data_i(src_data_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .dst_data_o(dst_data_o), .dst_valid_o(dst_valid_o), .dst_ready_i(dst_ready_i),
    .ring_dir_o(ring_dir_o), .ring_bypass_o(ring_bypass_o),
    .ring_conf_valid_o(ring_conf_valid_o),
    .ring_tx_data_o(ring_tx_data_o), .ring_tx_valid_o(ring_tx_valid_o),
    .ring_tx_ready_i(ring_tx_ready_i),
    .ring_rx_data_i(ring_rx_data_i), .ring_rx_valid_i(ring_rx_valid_i),
    .ring_rx_ready_o(ring_rx_ready_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {cmd_ready, conf_valid, tx_valid, src_ready, dst_valid, rx_ready, busy, done, dir, bypass}
  function automatic logic [9:0] out_vec();
    return {cmd_ready_o, ring_conf_valid_o, ring_tx_valid_o, src_ready_o, dst_valid_o,
            ring_rx_ready_o, busy_o, done_o, ring_dir_o, ring_bypass_o};
  endfunction

  // mode 0: router loops tx back to rx one cycle later; mode 1: router offers
  // an independent stream of rx words from the start.
  task automatic run_cmd(input bit d, input bit b, input int len, input int mode,
                         input int bp_pct, input int sv_pct, input int abort_at);
    int n, c, tx_n, rx_n, last_hs, conf_cnt, conf_cyc, done_cnt, done_cyc, rdy_cyc;
    int errs_hs, errs_busy;
    bit in_x, tx_hs, rx_hs, flood, aborted, exp_busy;
    logic [DW-1:0] rxq[$];
    int rxc[$];
    logic [DW-1:0] src_word, junk;

    n = b ? 0 : len;
    tx_n = 0; rx_n = 0; last_hs = 1; conf_cnt = 0; conf_cyc = -1;
    done_cnt = 0; done_cyc = -1; rdy_cyc = -1; errs_hs = 0; errs_busy = 0;
    aborted = 0;
    src_word = {$urandom, $urandom};
    junk = {$urandom, $urandom};
    if (mode == 1)
      for (int i = 0; i < len + 2; i++) begin
        rxq.push_back({$urandom, $urandom});
        rxc.push_back(0);
      end
    flood = (n == 0);

    for (c = 0; c < 300 && rdy_cyc < 0; c++) begin
      @(negedge clk_i);
      cmd_valid_i = (c == 0);
      cmd_i.dir = d;
      cmd_i.bypass = b;
      cmd_i.len = 16'(len);
      src_valid_i = ($urandom_range(99) < sv_pct);
      src_data_i = src_word;
      ring_tx_ready_i = ($urandom_range(99) < bp_pct);
      dst_ready_i = ($urandom_range(99) < bp_pct);
      if (rxq.size() > 0 && rxc[0] < c) begin
        ring_rx_valid_i = 1'b1; ring_rx_data_i = rxq[0];
      end else if (flood) begin
        ring_rx_valid_i = 1'b1; ring_rx_data_i = junk;
      end else begin
        ring_rx_valid_i = 1'b0; ring_rx_data_i = '0;
      end
      #1;
      if (c == 0) check_eq("cmd_ready_idle", cmd_ready_o, 1);

      in_x = (n > 0) && (c >= 2) && !(tx_n == n && rx_n == n);
      if (ring_tx_valid_o !== (in_x && src_valid_i && tx_n < n) ||
          src_ready_o     !== (in_x && ring_tx_ready_i && tx_n < n) ||
          dst_valid_o     !== (in_x && ring_rx_valid_i && rx_n < n) ||
          ring_rx_ready_o !== (in_x && dst_ready_i && rx_n < n))
        errs_hs++;

      exp_busy = (c >= 1) && !(done_cyc >= 0 && c > done_cyc);
      if (busy_o !== exp_busy) errs_busy++;
      if (c >= 1 && (ring_dir_o !== d || ring_bypass_o !== b)) errs_busy++;

      if (ring_conf_valid_o) begin conf_cnt++; conf_cyc = c; end
      if (done_o) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (c >= 1 && cmd_ready_o && rdy_cyc < 0) rdy_cyc = c;

      tx_hs = ring_tx_valid_o && ring_tx_ready_i;
      rx_hs = dst_valid_o && dst_ready_i;
      if (rx_hs) begin
        rx_n++; last_hs = c;
        if (rxq.size() > 0 && rxc[0] < c) begin
          check_eq("rx_data", dst_data_o, rxq[0]);
          void'(rxq.pop_front());
          void'(rxc.pop_front());
        end
      end
      if (tx_hs) begin
        tx_n++; last_hs = c;
        check_eq("tx_data", ring_tx_data_o, src_word);
        if (mode == 0) begin rxq.push_back(src_word); rxc.push_back(c); end
        src_word = {$urandom, $urandom};
      end
      flood = (rx_n >= n);
      if (abort_at > 0 && tx_n == abort_at) begin aborted = 1; break; end
    end

    if (aborted) begin
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      check_eq("abort_reset_outs", out_vec(), 10'b10_0000_0000);
      @(negedge clk_i);
      rst_i = 1'b0;
      $display("xfer aborted dir=%0d len=%0d after tx=%0d rx=%0d", d, len, tx_n, rx_n);
      return;
    end

    if (rdy_cyc < 0) check_eq("timeout", 0, 1);
    check_eq("conf_count", conf_cnt, 1);
    check_eq("conf_cycle", conf_cyc, 1);
    check_eq("tx_beats", tx_n, n);
    check_eq("rx_beats", rx_n, n);
    check_eq("done_count", done_cnt, 1);
    check_eq("done_cycle", done_cyc, (n == 0) ? 2 : last_hs + 1);
    check_eq("ready_cycle", rdy_cyc, done_cyc + 1);
    check_eq("handshake_rules", errs_hs, 0);
    check_eq("busy_cfg_hold", errs_busy, 0);
    $display("xfer dir=%0d bypass=%0d len=%0d mode=%0d tx=%0d rx=%0d done@%0d ready@%0d",
             d, b, len, mode, tx_n, rx_n, done_cyc, rdy_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check_eq("reset_outs", out_vec(), 10'b10_0000_0000);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_cmd(1, 0, 4, 0, 100, 100, 0);   // loopback, always ready
    run_cmd(0, 0, 3, 0, 50, 100, 0);    // random backpressure, valid held
    run_cmd(1, 1, 8, 1, 100, 100, 0);   // bypass
    run_cmd(0, 0, 0, 1, 100, 100, 0);   // len 0
    run_cmd(1, 0, 2, 1, 100, 100, 0);   // last tx and rx in the same cycle
    run_cmd(1, 0, 5, 0, 100, 100, 2);   // reset after 2 of 5 beats
    check_eq("post_reset_idle", out_vec(), 10'b10_0000_0000);
    run_cmd(0, 0, 1, 0, 100, 100, 0);

    for (int k = 0; k < 10; k++)
      run_cmd(1'($urandom_range(1)), ($urandom_range(5) == 0), $urandom_range(6),
              $urandom_range(1), $urandom_range(100, 30), $urandom_range(100, 50), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
